// File: rtl/bus_grant_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_grant_arbiter_pkg
// Description : Shared defaults and FSM state encoding for bus_grant_arbiter.
//               Optional macro BUS_GRANT_TIMEOUT_EN enables the tenure limit.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_grant_arbiter_pkg;

  localparam int c_num_req  = 32;
  localparam int c_code_w   = 5;
  localparam int c_max_hold = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/bus_grant_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : bus_grant_arbiter_rr_pick
// Description : Combinational round-robin picker. Rotates the request vector
//               so rr_ptr sits at bit 0, takes the lowest set bit, then maps
//               the result back to an absolute index and one-hot vector.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_grant_arbiter_rr_pick
  import bus_grant_arbiter_pkg::*;
#(
  parameter int NUM_REQ = c_num_req,
  parameter int CODE_W  = c_code_w
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [CODE_W-1:0]  rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [CODE_W-1:0]  win_code,
  output logic               any_req
);

  localparam logic [CODE_W:0] c_n = (CODE_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] req_rot;
  logic [CODE_W-1:0]  rot_first;

  // Rotate right by rr_ptr (modulo NUM_REQ) so the priority holder is bit 0
  always_comb begin
    logic [CODE_W:0] src;
    req_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src = {1'b0, CODE_W'(i)} + {1'b0, rr_ptr};
      if (src >= c_n) src = src - c_n;
      req_rot[i] = req[src[CODE_W-1:0]];
    end
  end

  // Fixed-priority pick of the lowest set bit in the rotated vector
  always_comb begin
    rot_first = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_first = CODE_W'(i);
    end
  end

  assign any_req = |req;

  // Un-rotate the pick back to an absolute index and its one-hot form
  always_comb begin
    logic [CODE_W:0] abs_idx;
    abs_idx = {1'b0, rot_first} + {1'b0, rr_ptr};
    if (abs_idx >= c_n) abs_idx = abs_idx - c_n;
    win_code = any_req ? abs_idx[CODE_W-1:0] : '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      win_onehot[j] = any_req && (win_code == CODE_W'(j));
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_grant_arbiter
// Description : Round-robin owner arbiter for the shared internal CPU bus.
//               Registered one-hot grant plus binary code, grant held for the
//               whole tenure, one turnaround cycle between owners.
//               Optional macro BUS_GRANT_TIMEOUT_EN: limits a tenure to
//               MAX_HOLD cycles and adds the timeout_pulse output.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_grant_arbiter
  import bus_grant_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = c_num_req,
  parameter int CODE_W   = c_code_w,
  parameter int MAX_HOLD = c_max_hold
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [CODE_W-1:0]  grant_code,
  output logic               grant_valid,
  output logic               turn
`ifdef BUS_GRANT_TIMEOUT_EN
  ,
  output logic               timeout_pulse
`endif
);

  // Reject configurations the picker and code width cannot represent
  if (NUM_REQ < 2 || NUM_REQ > 32 || CODE_W != $clog2(NUM_REQ) || MAX_HOLD < 1) begin : g_param_check
    $error("bus_grant_arbiter: illegal parameter combination");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [CODE_W-1:0]  pick_code;
  logic               pick_any;
  logic [CODE_W-1:0]  ptr_after_pick;
  logic               owner_req;
  logic               hold_expired;

  bus_grant_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .CODE_W  (CODE_W)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (pick_onehot),
    .win_code   (pick_code),
    .any_req    (pick_any)
  );

  // The current owner still wants the bus
  assign owner_req = |(req & grant_q);

  // Priority moves to the index just past the winner, wrapping at the top
  assign ptr_after_pick = (pick_code == CODE_W'(NUM_REQ - 1)) ? '0 : pick_code + CODE_W'(1);

`ifdef BUS_GRANT_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              to_pulse_q, to_pulse_d;

  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Hold counter: zero on entry to OWN, counts every cycle spent in OWN
  always_comb begin
    hold_d     = hold_q;
    to_pulse_d = (state_q == OWN) && owner_req && hold_expired;
    if (state_d == OWN && state_q != OWN) begin
      hold_d = '0;
    end else if (state_q == OWN) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Hold counter and timeout pulse registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hold_q     <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      to_pulse_q <= to_pulse_d;
    end
  end

  assign timeout_pulse = to_pulse_q;
`else
  assign hold_expired = 1'b0;
`endif

  // Next-state and grant computation; arbitration happens only in IDLE/TURN
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    code_d   = code_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE, TURN: begin
        if (pick_any) begin
          state_d  = OWN;
          grant_d  = pick_onehot;
          code_d   = pick_code;
          rr_ptr_d = ptr_after_pick;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          code_d  = '0;
        end
      end
      OWN: begin
        if (!owner_req || hold_expired) begin
          state_d = TURN;
          grant_d = '0;
          code_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        code_d  = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      code_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      code_q   <= code_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_code  = code_q;
  assign grant_valid = |grant_q;
  assign turn        = (state_q == TURN);

endmodule
`default_nettype wire

// File: tb/tb_bus_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_grant_arbiter
// Description : Self-checking bench for bus_grant_arbiter. Expected owners are
//               queued when requests are driven and popped when a new tenure
//               starts; directed checks cover latency, turnaround and reset.
//               Honours BUS_GRANT_TIMEOUT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_grant_arbiter;

  localparam int NUM_REQ  = 32;
  localparam int CODE_W   = 5;
  localparam int MAX_HOLD = 16;

  logic                clk = 1'b0;
  logic                clr_n = 1'b0;
  logic [NUM_REQ-1:0]  req = '0;
  logic [NUM_REQ-1:0]  grant;
  logic [CODE_W-1:0]   grant_code;
  logic                grant_valid;
  logic                turn;
`ifdef BUS_GRANT_TIMEOUT_EN
  logic                timeout_pulse;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  int unsigned exp_q[$];
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  bus_grant_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CODE_W   (CODE_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .req           (req),
    .grant         (grant),
    .grant_code    (grant_code),
    .grant_valid   (grant_valid),
    .turn          (turn)
`ifdef BUS_GRANT_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] g, input logic [31:0] c,
                            input logic [31:0] v, input logic [31:0] t);
    check_val({tag, "_grant"}, grant, g);
    check_val({tag, "_code"},  32'(grant_code), c);
    check_val({tag, "_valid"}, 32'(grant_valid), v);
    check_val({tag, "_turn"},  32'(turn), t);
  endtask

  task automatic apply_reset();
    clr_n = 1'b0;
    req   = '0;
    tick();
    tick();
    clr_n = 1'b1;
  endtask

  // Scoreboard: every new tenure must match the next queued owner
  always @(negedge clk) begin
    if (grant_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_extra", 32'(grant_code), 32'hFFFF_FFFF);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        check_val("sb_code", 32'(grant_code), e);
        check_val("sb_onehot", grant, 32'h1 << e);
      end
    end
    prev_valid <= grant_valid;
  end

  initial begin
    // Reset state
    tick();
    tick();
    expect_out("rst", 32'h0, 0, 0, 0);
    clr_n = 1'b1;

    // Single requester: 1-cycle latency, held while req stays high
    exp_q.push_back(4);
    req = 32'h0000_0010;
    tick();
    expect_out("t1", 32'h10, 4, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t1_hold", grant, 32'h10);
    end

    // Owner drops while req[7] rises: turnaround, then 7
    exp_q.push_back(7);
    req = 32'h0000_0080;
    tick();
    expect_out("t2_turn", 32'h0, 0, 0, 1);
    tick();
    expect_out("t2_own", 32'h80, 7, 1, 0);

    // Asynchronous reset mid-tenure
    tick();
    #3 clr_n = 1'b0;
    #1;
    expect_out("arst", 32'h0, 0, 0, 0);
    req = 32'h0000_0081;
    tick();
    expect_out("arst_hold", 32'h0, 0, 0, 0);
    clr_n = 1'b1;
    exp_q.push_back(0);
    tick();
    expect_out("arst_restart", 32'h1, 0, 1, 0);
    req = '0;
    tick();
    check_val("arst_end_turn", 32'(turn), 1);
    tick();
    expect_out("arst_idle", 32'h0, 0, 0, 0);

    // Fairness: all requesting, each owner releases after 2 cycles
    apply_reset();
    for (int t = 0; t <= NUM_REQ; t++) exp_q.push_back(t % NUM_REQ);
    req = '1;
    tick();
    for (int t = 0; t <= NUM_REQ; t++) begin
      int k;
      k = t % NUM_REQ;
      check_val("rr_c1", grant, 32'h1 << k);
      tick();
      check_val("rr_c2", grant, 32'h1 << k);
      req = ~(32'h1 << k);
      tick();
      expect_out("rr_turn", 32'h0, 0, 0, 1);
      req = (t == NUM_REQ) ? '0 : '1;
      tick();
    end
    expect_out("rr_idle", 32'h0, 0, 0, 0);

    // Wrap-around: rr_ptr at 31 with requests on 31 and 0
    apply_reset();
    exp_q.push_back(30);
    exp_q.push_back(31);
    exp_q.push_back(0);
    req = 32'h4000_0000;
    tick();
    check_val("wrap_30", 32'(grant_code), 30);
    req = 32'h8000_0001;
    tick();
    expect_out("wrap_turn1", 32'h0, 0, 0, 1);
    tick();
    expect_out("wrap_31", 32'h8000_0000, 31, 1, 0);
    req = 32'h0000_0001;
    tick();
    check_val("wrap_turn2", 32'(turn), 1);
    tick();
    expect_out("wrap_0", 32'h1, 0, 1, 0);
    req = '0;
    tick();
    tick();

`ifdef BUS_GRANT_TIMEOUT_EN
    // Tenure limit: owner 3 is forced out after MAX_HOLD cycles, then 5
    apply_reset();
    exp_q.push_back(3);
    exp_q.push_back(5);
    req = 32'h0000_0028;
    tick();
    check_val("to_first", grant, 32'h8);
    check_val("to_pulse_lo", 32'(timeout_pulse), 0);
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      check_val("to_hold", grant, 32'h8);
    end
    tick();
    expect_out("to_turn", 32'h0, 0, 0, 1);
    check_val("to_pulse", 32'(timeout_pulse), 1);
    tick();
    expect_out("to_next", 32'h20, 5, 1, 0);
    check_val("to_pulse_clr", 32'(timeout_pulse), 0);
`else
    // Without the tenure limit an owner keeps the bus indefinitely
    apply_reset();
    exp_q.push_back(3);
    exp_q.push_back(5);
    req = 32'h0000_0028;
    tick();
    for (int i = 0; i < MAX_HOLD + 8; i++) begin
      tick();
      check_val("nolim_hold", grant, 32'h8);
    end
    req = 32'h0000_0020;
    tick();
    expect_out("nolim_turn", 32'h0, 0, 0, 1);
    tick();
    expect_out("nolim_next", 32'h20, 5, 1, 0);
`endif
    req = '0;
    tick();
    tick();
    tick();
    check_val("sb_drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_grant_arbiter.md
Name: bus_grant_arbiter

Overview:
- Round-robin arbiter sharing the single internal CPU bus among up to 32 drivers (registers, ALU result, memory data, etc.).
- Takes per-driver request lines and issues a registered one-hot grant plus its 5-bit binary code for the bus-select mux.
- Holds a grant for the whole tenure and inserts one turnaround cycle between owners, so two drivers never overlap on the bus.

Parameters:
- NUM_REQ, 32, number of requesters; legal range 2..32.
- CODE_W, 5, width of grant_code; must equal ceil(log2(NUM_REQ)).
- MAX_HOLD, 16, tenure limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per driver; held high for the whole tenure.
- grant  out  NUM_REQ  registered one-hot grant; all-zero when the bus is idle.
- grant_code  out  CODE_W  binary index of the set grant bit; 0 when grant_valid=0.
- grant_valid  out  1  high exactly when grant is non-zero.
- turn  out  1  high during the one-cycle turnaround after a tenure ends.

Behaviour:
- Reset (clr_n low, asynchronous, any state):
  - grant=0, grant_code=0, grant_valid=0, turn=0, state=IDLE, rr_ptr=0.
  - Reset asserted mid-tenure drops the grant immediately; no turnaround cycle follows reset.
- States:
  - IDLE: if any req bit is set, latch the winner. Next cycle the state is OWN with grant, grant_code and grant_valid set. Request-to-grant latency is 1 cycle.
  - OWN: hold the grant while req[owner]=1. When req[owner]=0 is sampled, the next cycle enters TURN with grant=0 and turn=1.
  - TURN: lasts exactly 1 cycle, with turn=1 and grant=0. Arbitrate over the req bits present in this cycle: a winner goes to OWN next cycle, otherwise to IDLE.
- Round-robin:
  - rr_ptr points at the highest-priority index and defaults to 0.
  - The search runs rr_ptr, rr_ptr+1, ..., NUM_REQ-1, then wraps to 0.
  - On each grant, rr_ptr becomes winner+1, wrapping NUM_REQ-1 to 0.
- Fairness: with all requesters continuously active, each is granted once per NUM_REQ tenures.
- Simultaneous events:
  - Owner drops req in the same cycle others raise theirs: go to TURN; the new requests are arbitrated in TURN.
  - New requests from non-owners during OWN are ignored until TURN; there is no preemption.
- Request bits at index >= NUM_REQ are tied 0 and never granted.
- Invariants, true every cycle:
  - popcount(grant) <= 1.
  - grant_valid == |grant.
  - grant_code == index of the set grant bit, or 0 when no bit is set. grant_code is never x.

Optional Feature:
- Macro: BUS_GRANT_TIMEOUT_EN.
- With the macro: a hold counter clears on entry to OWN and increments every OWN cycle. When it reaches MAX_HOLD, the arbiter forces TURN even if req[owner]=1, and a 1-cycle timeout_pulse output port is added. The forced-out owner competes again in TURN at the lowest priority, because rr_ptr has already moved past it.
- Without the macro: no counter and no timeout_pulse port; a tenure is unbounded.

Decomposition:
- Shared package:
  - NUM_REQ and CODE_W defaults.
  - State encoding: IDLE=2'd0, OWN=2'd1, TURN=2'd2.
  - MAX_HOLD default.
- One sub-module, rr_pick (combinational):
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner, its binary code and an any-request flag.
  - Implementation: rotate, fixed-priority pick, un-rotate.
- The top level holds the FSM, rr_ptr, the grant registers and the optional hold counter.

Test Plan:
- Reset then req=32'h0000_0010 → 1 cycle later grant=32'h10, grant_code=4, grant_valid=1; it holds while req stays high.
- Owner 4 drops req while req[7] rises in the same cycle → next cycle grant=0, turn=1; the cycle after, grant=32'h80, grant_code=7.
- req=32'hFFFF_FFFF held, each owner releasing after 2 cycles → grant order 0, 1, 2, …, 31, 0, with a single turnaround cycle between tenures.
- req=32'h8000_0001 with rr_ptr=31 → grant_code=31 first, then 0 after the turnaround (wrap-around check).
- clr_n pulsed low mid-tenure, asynchronously between clock edges → grant=0 and grant_code=0 immediately; after release, arbitration restarts at index 0.
- BUS_GRANT_TIMEOUT_EN defined, MAX_HOLD=16, req[3] held high with req[5] also high → grant to 3 drops after 16 cycles with timeout_pulse=1, turn follows, then grant_code=5.
